grf_sb: RTL
===========

Name: grf_sb

Overview:
- Parametrised general register file for the pipelined core, with a per-register pending-write scoreboard.
- Provides NRD combinational read ports with same-cycle write bypass, one synchronous write port, and register 0 hardwired to zero.
- Tracks in-flight writes issued by decode, so hazard logic can stall on a per-register ready flag instead of comparing stage addresses.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports.
- CNT_W, 2, width of each pending-write counter; counter maximum = 2**CNT_W-1.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- RA  in  NRD*ADDR_W  read addresses; port i is RA[i*ADDR_W +: ADDR_W].
- RD  out  NRD*DATA_W  read data; port i is RD[i*DATA_W +: DATA_W].
- RRdy  out  NRD  port i: no outstanding write to RA[i] after this cycle's writeback.
- WE  in  1  write enable; also releases one pending count for WA.
- WA  in  ADDR_W  write address.
- Wdata  in  DATA_W  write data.
- Pc  in  32  PC of the writing instruction; used for trace only.
- IssueEn  in  1  decode issued an instruction that will write IssueA.
- IssueA  in  ADDR_W  destination of the issued instruction.
- Flush  in  1  clear every pending counter; register contents are kept.
- PendAny  out  1  OR over all pending counters (registered state).
- ScErr  out  1  sticky error: issue attempted while the counter was already at maximum.

Behaviour:
- Reset (synchronous, active-high) has priority over all other inputs.
  - All registers, all counters and ScErr go to 0 at the next edge.
  - Reset asserted while counts are pending discards those counts.
- Write:
  - On the edge with WE=1 and WA!=0, reg[WA] <= Wdata.
  - WA=0 writes are discarded; reg[0] always reads 0.
- Read, combinational:
  - RA[i]=0 gives RD=0.
  - Else if WE and WA==RA[i], RD=Wdata (bypass).
  - Else RD=reg[RA[i]].
  - All ports are independent; any number may address the same register.
- Counter cnt[r], one per register r!=0; cnt[0] is constant 0. Next-state per edge, first matching rule wins:
  1. Reset or Flush: 0.
  2. inc = IssueEn && IssueA==r && r!=0; dec = WE && WA==r && cnt[r]!=0.
  3. inc and dec together: unchanged.
  4. inc only: +1 if cnt[r] < max; otherwise unchanged and ScErr <= 1.
  5. dec only: -1.
  6. WE to a register with cnt=0 is legal: data is written, no count change, no error.
- RRdy[i] = 1 when any of the following holds:
  - RA[i]==0;
  - cnt[RA[i]]==0;
  - cnt[RA[i]]==1 and WE and WA==RA[i], i.e. the last outstanding write is bypassed this cycle.
- RRdy does not consider same-cycle IssueEn; decode's own issue is not a hazard against itself.
- PendAny is derived from current cnt state only, with no combinational path from inputs.
- ScErr clears only on Reset; Flush does not clear it.
- Latency:
  - Reads and bypass: 0 cycles.
  - Written data visible from storage 1 cycle after the write edge.
  - Counter effects visible on RRdy in the cycle after the edge.

Optional Feature:
- GRF_TRACE_EN defined: every accepted write edge (WE=1, Reset=0) executes $display("%d@%h: $%d <= %h", $time, Pc, WA, Wdata).
  - This includes WA=0, which prints the attempted value.
- Undefined: no display statements; Pc is unused and functionally ignored.

Test Plan:
- Reset then read: RA={5'd3,5'd0} -> RD all 0, RRdy=2'b11, PendAny=0, ScErr=0.
- Write/bypass: WE=1, WA=8, Wdata=32'hDEADBEEF, RA0=8 -> RD0=DEADBEEF in the same cycle; next cycle with WE=0 -> RD0=DEADBEEF from storage.
- Zero register: WE=1, WA=0, Wdata=32'h12345678 -> RD for RA=0 stays 0 in the same and next cycles; with GRF_TRACE_EN, one trace line is printed.
- Scoreboard:
  - Issue r5 twice on consecutive cycles -> cnt=2, RRdy(r5)=0, PendAny=1.
  - WE to r5 -> RRdy stays 0 in that cycle.
  - Second WE to r5 -> RRdy=1 in that same cycle via bypass; PendAny=0 after the edge.
- Simultaneous and overflow:
  - IssueEn+WE both to r7 with cnt=1 -> cnt stays 1.
  - Four issues to r9 (CNT_W=2) -> cnt=3, ScErr=1 after the 4th edge.
  - Flush -> all RRdy=1, ScErr still 1; Reset -> ScErr=0.
- Reset mid-operation: cnt(r4)=2 and reg4=32'hA5, assert Reset with WE=1 to r4 -> next cycle reg4=0, cnt=0, RRdy=1.

Source files
------------

// File: rtl/grf_sb.sv
// grf_sb: general register file with NRD bypassed read ports, one write port and
// a per-register pending-write scoreboard. Define GRF_TRACE_EN for write tracing.
module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NRD*ADDR_W-1:0]    RA,
    output logic [NRD*DATA_W-1:0]    RD,
    output logic [NRD-1:0]           RRdy,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WA,
    input  logic [DATA_W-1:0]        Wdata,
    input  logic [31:0]              Pc,
    input  logic                     IssueEn,
    input  logic [ADDR_W-1:0]        IssueA,
    input  logic                     Flush,
    output logic                     PendAny,
    output logic                     ScErr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];
    logic              scerr_q, scerr_d;

    logic              inc, dec;

    always_comb begin
        scerr_d = scerr_q;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
            inc      = IssueEn && (IssueA == ADDR_W'(r));
            dec      = WE && (WA == ADDR_W'(r)) && (cnt_q[r] != '0);
            if (Flush || r == 0) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                if (cnt_q[r] != CNT_MAX)
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                else
                    scerr_d = 1'b1;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            scerr_q <= 1'b0;
        end else begin
            if (WE && (WA != '0))
                regs_q[WA] <= Wdata;
            for (int r = 0; r < DEPTH; r++)
                cnt_q[r] <= cnt_d[r];
            scerr_q <= scerr_d;
        end
    end

    logic [ADDR_W-1:0] ra;
    logic              hit;

    // A port is ready when the only outstanding write is the one being bypassed now.
    always_comb begin
        RD   = '0;
        RRdy = '0;
        ra   = '0;
        hit  = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra  = RA[i*ADDR_W +: ADDR_W];
            hit = WE && (WA == ra);
            if (ra == '0) begin
                RD[i*DATA_W +: DATA_W] = '0;
                RRdy[i]                = 1'b1;
            end else begin
                RD[i*DATA_W +: DATA_W] = hit ? Wdata : regs_q[ra];
                RRdy[i] = (cnt_q[ra] == '0) || ((cnt_q[ra] == CNT_ONE) && hit);
            end
        end
    end

    always_comb begin
        PendAny = 1'b0;
        for (int r = 0; r < DEPTH; r++)
            PendAny = PendAny | (|cnt_q[r]);
    end

    assign ScErr = scerr_q;

`ifdef GRF_TRACE_EN
    always @(posedge Clk) begin
        if (WE && !Reset)
            $display("%d@%h: $%d <= %h", $time, Pc, WA, Wdata);
    end
`else
    logic unused_pc;
    assign unused_pc = ^Pc;
`endif

endmodule
